// File: rtl/mem_req_arbiter_if.sv
// Cache-side request/response bundle plus the single memory-side port of the
// round-robin memory arbiter. master = arbiter view, slave = caches + memory.
interface mem_req_arbiter_if #(
  parameter int NUM_PORTS = 2,
  parameter int BLOCKSIZE = 128,
  parameter int ADDR_W    = 32
);
  logic [NUM_PORTS-1:0]           req_valid;
  logic [NUM_PORTS-1:0]           req_wen;
  logic [NUM_PORTS*ADDR_W-1:0]    req_addr;
  logic [NUM_PORTS*BLOCKSIZE-1:0] req_wdata;
  logic [NUM_PORTS-1:0]           resp_ready;
  logic [BLOCKSIZE-1:0]           resp_rdata;

  logic                           mem_valid;
  logic                           mem_wen;
  logic [ADDR_W-1:0]              mem_addr;
  logic [BLOCKSIZE-1:0]           mem_wdata;
  logic                           mem_ready;
  logic [BLOCKSIZE-1:0]           mem_rdata;

  modport master (
    input  req_valid, req_wen, req_addr, req_wdata, mem_ready, mem_rdata,
    output resp_ready, resp_rdata, mem_valid, mem_wen, mem_addr, mem_wdata
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_wdata, mem_ready, mem_rdata,
    input  resp_ready, resp_rdata, mem_valid, mem_wen, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_req_arbiter.sv
// N-port round-robin arbiter sharing one main-memory port, one transaction in flight.
// Optional MEM_ARB_PERF_EN adds per-port saturating grant and wait counters.
module mem_req_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int BLOCKSIZE = 128,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_req_arbiter_if.master bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [NUM_PORTS*32-1:0] perf_grants,
  output logic [NUM_PORTS*32-1:0] perf_wait
`endif
);

  localparam int PW = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        gnt_q, gnt_d;
  logic                 mem_valid_q, mem_valid_d;
  logic                 mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [BLOCKSIZE-1:0] mem_wdata_q, mem_wdata_d;
  logic [BLOCKSIZE-1:0] resp_rdata_q, resp_rdata_d;
  logic [NUM_PORTS-1:0] resp_ready_q, resp_ready_d;

  logic          found;
  logic [PW-1:0] pick;
  int            idx;

  // First requesting port at or above the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = (int'(ptr_q) + i) % NUM_PORTS;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_d        = gnt_q;
    mem_valid_d  = mem_valid_q;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    resp_rdata_d = resp_rdata_q;
    resp_ready_d = '0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d       = pick;
          mem_valid_d = 1'b1;
          mem_wen_d   = bus.req_wen[pick];
          mem_addr_d  = bus.req_addr[int'(pick)*ADDR_W +: ADDR_W];
          mem_wdata_d = bus.req_wdata[int'(pick)*BLOCKSIZE +: BLOCKSIZE];
          state_d     = BUSY;
        end
      end
      BUSY: begin
        if (bus.mem_ready) begin
          resp_rdata_d        = bus.mem_rdata;
          resp_ready_d[gnt_q] = 1'b1;
          mem_valid_d         = 1'b0;
          ptr_d               = (gnt_q == PW'(NUM_PORTS - 1)) ? '0 : gnt_q + 1'b1;
          state_d             = RESP;
        end
      end
      // The served requester drops its valid during RESP, so IDLE never re-grants it stale.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      gnt_q        <= '0;
      mem_valid_q  <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rdata_q <= '0;
      resp_ready_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_q        <= gnt_d;
      mem_valid_q  <= mem_valid_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rdata_q <= resp_rdata_d;
      resp_ready_q <= resp_ready_d;
    end
  end

  assign bus.mem_valid  = mem_valid_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.resp_ready = resp_ready_q;
  assign bus.resp_rdata = resp_rdata_q;

`ifdef MEM_ARB_PERF_EN
  logic resp_enter;
  assign resp_enter = (state_q == BUSY) && bus.mem_ready;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_perf
    logic [31:0] grants_q;
    logic [31:0] wait_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        grants_q <= '0;
        wait_q   <= '0;
      end else begin
        if (resp_enter && (gnt_q == PW'(p)) && (grants_q != '1))
          grants_q <= grants_q + 32'd1;
        if (bus.req_valid[p] && !resp_ready_q[p] && (wait_q != '1))
          wait_q <= wait_q + 32'd1;
      end
    end

    assign perf_grants[p*32 +: 32] = grants_q;
    assign perf_wait[p*32 +: 32]   = wait_q;
  end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a 2-port and a 4-port instance share clk/rst.
// Define MEM_ARB_PERF_EN to also exercise the performance counters.
module tb_mem_req_arbiter;
  localparam int BS = 128;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  mem_req_arbiter_if #(.NUM_PORTS(2), .BLOCKSIZE(BS), .ADDR_W(AW)) m2 ();
  mem_req_arbiter_if #(.NUM_PORTS(4), .BLOCKSIZE(BS), .ADDR_W(AW)) m4 ();

`ifdef MEM_ARB_PERF_EN
  logic [2*32-1:0] pg2, pw2;
  logic [4*32-1:0] pg4, pw4;
`endif

  mem_req_arbiter #(.NUM_PORTS(2), .BLOCKSIZE(BS), .ADDR_W(AW)) dut2 (
    .clk(clk), .rst(rst), .bus(m2.master)
`ifdef MEM_ARB_PERF_EN
    , .perf_grants(pg2), .perf_wait(pw2)
`endif
  );

  mem_req_arbiter #(.NUM_PORTS(4), .BLOCKSIZE(BS), .ADDR_W(AW)) dut4 (
    .clk(clk), .rst(rst), .bus(m4.master)
`ifdef MEM_ARB_PERF_EN
    , .perf_grants(pg4), .perf_wait(pw4)
`endif
  );

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_mv(input bit four, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = four ? m4.mem_valid : m2.mem_valid;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL %s_timeout: mem_valid still 0 after 50 cycles, required 1", tag);
    end
  endtask

  task automatic serve2(input int lat, input logic [BS-1:0] rd);
    repeat (lat - 1) @(negedge clk);
    m2.mem_ready = 1'b1;
    m2.mem_rdata = rd;
    @(negedge clk);
    m2.mem_ready = 1'b0;
    m2.mem_rdata = {4{32'hBAD0_BAD0}};
  endtask

  // Port 0 reads 0x100, port 1 writes all-ones to 0x200; both raised together.
  task automatic run_pair(input int lat, input string tag);
    m2.req_addr  = {32'h0000_0200, 32'h0000_0100};
    m2.req_wen   = 2'b10;
    m2.req_wdata = {{BS{1'b1}}, {BS{1'b0}}};
    m2.req_valid = 2'b11;
    wait_mv(1'b0, tag);
    n_checks++;
    if ({m2.mem_wen, m2.mem_addr} !== {1'b0, 32'h0000_0100})
      $display("FAIL %s_first: got wen=%0b addr=%h, required wen=0 addr=00000100", tag, m2.mem_wen, m2.mem_addr);
    else n_pass++;
    serve2(lat, {4{32'h1111_2222}});
    n_checks++;
    if (m2.resp_ready !== 2'b01) $display("FAIL %s_resp0: got %b, required 01", tag, m2.resp_ready);
    else n_pass++;
    m2.req_valid[0] = 1'b0;
    wait_mv(1'b0, tag);
    n_checks++;
    if ({m2.mem_wen, m2.mem_addr, m2.mem_wdata} !== {1'b1, 32'h0000_0200, {BS{1'b1}}})
      $display("FAIL %s_second: got wen=%0b addr=%h wdata=%h, required wen=1 addr=00000200 wdata=all-ones",
               tag, m2.mem_wen, m2.mem_addr, m2.mem_wdata);
    else n_pass++;
    serve2(lat, {4{32'h3333_4444}});
    n_checks++;
    if (m2.resp_ready !== 2'b10) $display("FAIL %s_resp1: got %b, required 10", tag, m2.resp_ready);
    else n_pass++;
    m2.req_valid[1] = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({m2.mem_valid, m2.mem_wen, m2.mem_addr, m2.mem_wdata, m2.resp_ready, m2.resp_rdata} !== '0)
      $display("FAIL reset_outputs2: got valid=%0b wen=%0b addr=%h ready=%b rdata=%h, required all 0",
               m2.mem_valid, m2.mem_wen, m2.mem_addr, m2.resp_ready, m2.resp_rdata);
    else n_pass++;
    n_checks++;
    if ({m4.mem_valid, m4.mem_addr, m4.resp_ready} !== '0)
      $display("FAIL reset_outputs4: got valid=%0b addr=%h ready=%b, required all 0",
               m4.mem_valid, m4.mem_addr, m4.resp_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (m2.mem_valid !== 1'b0) $display("FAIL idle_no_req: got mem_valid=%0b, required 0", m2.mem_valid);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int waited [4];
    int max_wait;
    int g;
    int exp;
    max_wait = 0;
    for (int p = 0; p < 4; p++) begin
      waited[p] = 0;
      m4.req_addr[p*AW +: AW] = 32'h100 * (p + 1);
    end
    m4.req_wen   = 4'b0000;
    m4.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp = k % 4;
      wait_mv(1'b1, "rr");
      n_checks++;
      if (m4.mem_addr !== 32'(32'h100 * (exp + 1)))
        $display("FAIL rr_grant%0d: got addr=%h, required %h", k, m4.mem_addr, 32'h100 * (exp + 1));
      else n_pass++;
      m4.mem_ready = 1'b1;
      m4.mem_rdata = BS'(k);
      @(negedge clk);
      m4.mem_ready = 1'b0;
      n_checks++;
      if (m4.resp_ready !== 4'(1 << exp))
        $display("FAIL rr_resp%0d: got %b, required %b", k, m4.resp_ready, 4'(1 << exp));
      else n_pass++;
      g = -1;
      for (int p = 0; p < 4; p++) if (m4.resp_ready[p]) g = p;
      for (int p = 0; p < 4; p++) begin
        if (p == g) begin
          if (waited[p] > max_wait) max_wait = waited[p];
          waited[p] = 0;
        end else begin
          waited[p]++;
        end
      end
    end
    m4.req_valid = 4'b0000;
    n_checks++;
    if (max_wait > 3) $display("FAIL rr_fairness: got max wait %0d grants, required <= 3", max_wait);
    else n_pass++;
  endtask

  task automatic test_single_read();
    logic [BS-1:0] blk;
    blk = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hCAFE_F00D};
    m2.req_addr[0 +: AW] = 32'h0000_1000;
    m2.req_wen[0]        = 1'b0;
    m2.req_valid         = 2'b01;
    @(negedge clk);
    n_checks++;
    if ({m2.mem_valid, m2.mem_wen, m2.mem_addr} !== {1'b1, 1'b0, 32'h0000_1000})
      $display("FAIL sr_issue: got valid=%0b wen=%0b addr=%h, required valid=1 wen=0 addr=00001000",
               m2.mem_valid, m2.mem_wen, m2.mem_addr);
    else n_pass++;
    serve2(4, blk);
    n_checks++;
    if ({m2.resp_ready, m2.resp_rdata} !== {2'b01, blk})
      $display("FAIL sr_resp: got ready=%b rdata=%h, required ready=01 rdata=%h", m2.resp_ready, m2.resp_rdata, blk);
    else n_pass++;
    m2.req_valid = 2'b00;
    @(negedge clk);
    n_checks++;
    if ({m2.resp_ready, m2.mem_valid, m2.resp_rdata} !== {2'b00, 1'b0, blk})
      $display("FAIL sr_after: got ready=%b valid=%0b rdata=%h, required ready=00 valid=0 rdata held",
               m2.resp_ready, m2.mem_valid, m2.resp_rdata);
    else n_pass++;
  endtask

  task automatic test_contention();
    do_reset();
    run_pair(3, "cont_a");
    run_pair(2, "cont_b");
  endtask

  task automatic test_stall();
    logic [BS-1:0] pat;
    pat = {32'hA5A5_0001, 32'h5A5A_0002, 32'hF0F0_0003, 32'h0F0F_0004};
    m2.req_addr[AW +: AW]  = 32'h0000_3000;
    m2.req_wdata[BS +: BS] = pat;
    m2.req_wen             = 2'b10;
    m2.req_valid           = 2'b10;
    wait_mv(1'b0, "stall");
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if ({m2.mem_valid, m2.mem_wen, m2.mem_addr, m2.mem_wdata, m2.resp_ready} !== {1'b1, 1'b1, 32'h0000_3000, pat, 2'b00})
        $display("FAIL stall_hold%0d: got valid=%0b wen=%0b addr=%h ready=%b, required 1 1 00003000 00",
                 i, m2.mem_valid, m2.mem_wen, m2.mem_addr, m2.resp_ready);
      else n_pass++;
      @(negedge clk);
    end
    serve2(1, {4{32'h7777_8888}});
    n_checks++;
    if (m2.resp_ready !== 2'b10) $display("FAIL stall_resp: got %b, required 10", m2.resp_ready);
    else n_pass++;
    m2.req_valid = 2'b00;
  endtask

  task automatic test_reset_mid_busy();
    // A completed port-0 read leaves the pointer at 1 before the reset.
    m2.req_addr[0 +: AW] = 32'h0000_4000;
    m2.req_wen           = 2'b00;
    m2.req_valid         = 2'b01;
    wait_mv(1'b0, "mid_pre");
    serve2(1, {4{32'h5555_6666}});
    m2.req_valid = 2'b00;
    @(negedge clk);
    m2.req_valid = 2'b01;
    wait_mv(1'b0, "mid_busy");
    @(negedge clk);
    rst          = 1'b1;
    m2.req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({m2.mem_valid, m2.mem_wen, m2.mem_addr, m2.mem_wdata, m2.resp_ready, m2.resp_rdata} !== '0)
      $display("FAIL mid_rst_outputs: got valid=%0b addr=%h ready=%b rdata=%h, required all 0",
               m2.mem_valid, m2.mem_addr, m2.resp_ready, m2.resp_rdata);
    else n_pass++;
    // A stray mem_ready in IDLE must be ignored.
    m2.mem_ready = 1'b1;
    m2.mem_rdata = {4{32'h9999_AAAA}};
    @(negedge clk);
    m2.mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m2.resp_ready, m2.mem_valid, m2.resp_rdata} !== '0)
      $display("FAIL mid_rst_no_resp: got ready=%b valid=%0b rdata=%h, required all 0",
               m2.resp_ready, m2.mem_valid, m2.resp_rdata);
    else n_pass++;
    run_pair(2, "mid_after");
  endtask

`ifdef MEM_ARB_PERF_EN
  task automatic test_perf();
    do_reset();
    run_pair(3, "perf");
    @(negedge clk);
    n_checks++;
    if (pg2 !== {32'd1, 32'd1}) $display("FAIL perf_grants: got %h, required 0000000100000001", pg2);
    else n_pass++;
    n_checks++;
    if (pw2 !== {32'd9, 32'd4}) $display("FAIL perf_wait: got p1=%0d p0=%0d, required p1=9 p0=4", pw2[63:32], pw2[31:0]);
    else n_pass++;
    n_checks++;
    if (pw2[63:32] - pw2[31:0] !== 32'd5)
      $display("FAIL perf_wait_diff: got %0d, required 5", pw2[63:32] - pw2[31:0]);
    else n_pass++;
  endtask
`endif

  initial begin
    m2.req_valid = '0; m2.req_wen = '0; m2.req_addr = '0; m2.req_wdata = '0;
    m2.mem_ready = 1'b0; m2.mem_rdata = '0;
    m4.req_valid = '0; m4.req_wen = '0; m4.req_addr = '0; m4.req_wdata = '0;
    m4.mem_ready = 1'b0; m4.mem_rdata = '0;

    test_reset();
    test_round_robin();
    test_single_read();
    test_contention();
    test_stall();
    test_reset_mid_busy();
`ifdef MEM_ARB_PERF_EN
    test_perf();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- N-port round-robin arbiter between L1 caches (instruction, data, future extra cores) and the single main-memory port.
- Each port uses the cache-to-memory block handshake (Valid/Wen/Addr/WriteD in, Ready/ReadD out).
- Generalises block width and channel count.
- Adds fair arbitration, registered outputs and one-outstanding-transaction tracking, so the instruction and data caches can share memory without hand-wired muxing.

Parameters:
- NUM_PORTS, 2, number of cache requesters; legal range >= 2.
- BLOCKSIZE, 128, block data width in bits; matches the cache line size.
- ADDR_W, 32, request address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_wen  in  NUM_PORTS  per-port write enable: 1 = write-back, 0 = block fill.
- req_addr  in  NUM_PORTS*ADDR_W  per-port block address, flattened; port p occupies bits [p*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_PORTS*BLOCKSIZE  per-port write block, flattened the same way.
- resp_ready  out  NUM_PORTS  one-cycle completion pulse to the granted port.
- resp_rdata  out  BLOCKSIZE  read block, shared by all ports; valid only in the cycle its resp_ready bit is high.
- mem_valid  out  1  request to memory.
- mem_wen  out  1  write enable to memory.
- mem_addr  out  ADDR_W  address to memory.
- mem_wdata  out  BLOCKSIZE  write block to memory.
- mem_ready  in  1  memory completion pulse.
- mem_rdata  in  BLOCKSIZE  memory read block; sampled when mem_ready = 1.

Behaviour:
- Reset (rst = 1 at a rising edge):
  - state = IDLE, priority pointer = 0.
  - All outputs driven to 0: resp_ready, resp_rdata, mem_valid, mem_wen, mem_addr, mem_wdata.
- Reset mid-transaction:
  - Any in-flight memory access is abandoned; no resp_ready is issued for it.
  - Memory shares rst and is reset in the same cycle.
- Requester rules:
  - Once req_valid[p] is raised, it must be held with addr/wen/wdata stable until resp_ready[p].
  - The requester drops req_valid[p] in the cycle after resp_ready[p], unless it is issuing a new request.
- State IDLE:
  - If any req_valid bit is set, grant the first set bit scanning from the pointer upward, wrapping modulo NUM_PORTS.
  - Register g, mem_addr, mem_wen and mem_wdata from port g, set mem_valid = 1, go to BUSY.
  - With no request, stay in IDLE with mem_valid = 0.
- State BUSY:
  - mem_* outputs are held stable while mem_ready = 0; arbiter latency is unbounded.
  - On mem_ready = 1: capture mem_rdata into resp_rdata, set resp_ready[g] = 1 for the next cycle, clear mem_valid, set pointer = (g+1) mod NUM_PORTS, go to RESP.
- State RESP:
  - Lasts one cycle with resp_ready[g] = 1; all other resp_ready bits are 0.
  - Next state is IDLE. Requests arriving during BUSY or RESP wait and are re-evaluated in IDLE.
- Latency:
  - req_valid sampled in IDLE at cycle T gives mem_valid = 1 at T+1.
  - mem_ready at cycle M gives resp_ready at M+1.
  - The earliest next grant is issued at M+2, with mem_valid = 1 at M+3.
  - Minimum turnaround is 3 cycles per transaction plus memory latency.
- resp_rdata holds its last captured value outside RESP. For writes it carries whatever mem_rdata held, and requesters ignore it.
- Fairness: a continuously requesting port waits for at most NUM_PORTS-1 other transactions before being granted.
- Simultaneous events:
  - A req_valid rising in the same cycle as mem_ready is not granted before the next IDLE.
  - mem_ready outside BUSY is ignored.
- Only one transaction is outstanding at a time; there is no reordering.

Optional Feature:
- Macro MEM_ARB_PERF_EN.
- When defined, adds output perf_grants (NUM_PORTS*32, flattened): per-port saturating 32-bit counters, each incremented on entry to RESP for its port.
- Also adds output perf_wait (NUM_PORTS*32, flattened): per-port saturating counters incremented on every cycle where req_valid[p] = 1 and resp_ready[p] = 0.
- Both counter sets clear on rst.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Single read: reset; port 0 requests Addr = 0x0000_1000, wen = 0; memory returns 0xDEADBEEF_... after 4 cycles. Required: mem_valid one cycle after the request, mem_addr = 0x1000, resp_ready[0] one cycle after mem_ready, resp_rdata equals the returned block, resp_ready[1] stays 0.
- Contention: both ports request in the same cycle with pointer = 0 (port 0 read at 0x100, port 1 write at 0x200, wdata = all-ones). Required: port 0 served first, then port 1 with mem_wen = 1 and mem_wdata = all-ones; pointer = 0 after both complete.
- Round-robin, NUM_PORTS = 4: all ports request continuously for 8 transactions. Required: grant order 0,1,2,3,0,1,2,3; no port waits for more than 3 other grants.
- Stall hold: mem_ready held low for 20 cycles. Required: mem_valid, mem_addr and mem_wdata stable for all 20 cycles; resp_ready stays 0 until mem_ready.
- Reset mid-BUSY: assert rst 2 cycles after mem_valid rises. Required: all outputs 0 next cycle, state IDLE, no resp_ready issued; a later port 1 request is granted first, since the pointer is back at 0 and port 0 is idle.
- With MEM_ARB_PERF_EN: contention case above with a 3-cycle memory. Required: perf_grants = {1,1}; perf_wait for port 1 exceeds perf_wait for port 0 by exactly the length of port 0's transaction, 3-cycle memory plus arbitration overhead.
